// File: rtl/axis_slave.sv
// AXI4-Stream slave front end: a small first-word-fall-through FIFO between the
// upstream stream and the core, with an occupancy count and a delivered-packet counter.
module axis_slave #(
    parameter int FIFO_DEPTH           = 4,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     TDATA_out,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   TSTRB_out,
    output logic                                TLAST_out,
    output logic                                TVALID_out,
    input  logic                                TREADY_in,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
    output logic [15:0]                         frame_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = C_S_AXIS_TDATA_WIDTH;
    localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [STRB_W-1:0] strb_mem [FIFO_DEPTH];
    logic              last_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             ready_q;
    logic             wr_en;
    logic             rd_en;

    // Ready is registered from the next occupancy, so the core's TREADY_in never
    // reaches S_AXIS_TREADY combinationally; a full FIFO stays blocked this cycle.
    assign S_AXIS_TREADY = ready_q && !S_AXIS_ARESET;
    assign wr_en         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign rd_en         = (count_q != '0) && TREADY_in;

    always_comb begin
        count_next = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (last_mem[rd_ptr]) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
            count_q <= count_next;
            ready_q <= (count_next < DEPTH_C);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) begin
            data_mem[wr_ptr] <= S_AXIS_TDATA;
            strb_mem[wr_ptr] <= S_AXIS_TSTRB;
            last_mem[wr_ptr] <= S_AXIS_TLAST;
        end
    end

    assign TDATA_out  = data_mem[rd_ptr];
    assign TSTRB_out  = strb_mem[rd_ptr];
    assign TLAST_out  = last_mem[rd_ptr];
    assign TVALID_out = (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_axis_slave.sv
// Bench for axis_slave: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized stream.
module tb_axis_slave;

    localparam int D = 4;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  tdata = '0;
    logic [W/8-1:0] tstrb = '0;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready_s;
    logic [W-1:0]  dout;
    logic [W/8-1:0] sout;
    logic          lout;
    logic          vout;
    logic          tready_in = 1'b0;
    logic [2:0]    fcount;
    logic [15:0]   fcnt;

    int total = 0;
    int bad   = 0;

    axis_slave #(.FIFO_DEPTH(D), .C_S_AXIS_TDATA_WIDTH(W)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready_s),
        .TDATA_out     (dout),
        .TSTRB_out     (sout),
        .TLAST_out     (lout),
        .TVALID_out    (vout),
        .TREADY_in     (tready_in),
        .fifo_count    (fcount),
        .frame_cnt     (fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered beats and a packet tally.
    typedef struct packed {
        logic [W-1:0]   d;
        logic [W/8-1:0] s;
        logic           l;
    } beat_t;

    beat_t       mq[$];
    logic [15:0] mframes  = '0;
    bit          m_in_rst = 1'b1;
    bit          started  = 1'b0;

    always @(posedge clk) begin
        bit do_rd;
        bit do_wr;
        if (rst) begin
            mq.delete();
            mframes  = '0;
            m_in_rst = 1'b1;
        end else begin
            do_rd = (mq.size() != 0) && tready_in;
            do_wr = tvalid && !m_in_rst && (mq.size() < D);
            if (do_rd) begin
                if (mq[0].l) mframes = mframes + 16'd1;
                void'(mq.pop_front());
            end
            if (do_wr) mq.push_back('{d: tdata, s: tstrb, l: tlast});
            m_in_rst = 1'b0;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", 64'(tready_s), 64'(!m_in_rst && !rst && (mq.size() < D)));
            chk("tvalid_out", 64'(vout), 64'(mq.size() != 0));
            chk("fifo_count", 64'(fcount), 64'(mq.size()));
            chk("frame_cnt", 64'(fcnt), 64'(mframes));
            if (mq.size() != 0) begin
                chk("tdata_out", 64'(dout), 64'(mq[0].d));
                chk("tstrb_out", 64'(sout), 64'(mq[0].s));
                chk("tlast_out", 64'(lout), 64'(mq[0].l));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int stalls = 0;

    task automatic send_beat(input logic [W-1:0] d, input logic [W/8-1:0] s, input logic l);
        bit acc;
        int n;
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            acc = tready_s;
            if (!acc) stalls++;
            cyc();
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        tready_in = 1'b1;
        n = 0;
        while (vout && n < 60) begin
            cyc();
            n++;
        end
        if (vout) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        tvalid    = 1'b0;
        tready_in = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        int idx;
        int guard;
        bit acc;

        // Reset for two cycles, then release.
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_ready", 64'(tready_s), 64'd1);
        chk("rst_tvalid", 64'(vout), 64'd0);
        chk("rst_count", 64'(fcount), 64'd0);
        chk("rst_frame", 64'(fcnt), 64'd0);

        // Back-to-back stream 0..31 with the core always ready.
        tready_in = 1'b1;
        stalls = 0;
        for (int i = 0; i < 32; i++) send_beat(W'(i), 4'hF, i == 31);
        chk("b2b_stalls", 64'(stalls), 64'd0);
        drain();
        chk("b2b_frame", 64'(fcnt), 64'd1);

        // Core stalled: four beats fill the FIFO, the fifth is held off.
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(W'(i), 4'h3, 1'b0);
        tvalid = 1'b1;
        tdata  = 32'd4;
        cyc();
        cyc();
        chk("full_count", 64'(fcount), 64'd4);
        chk("full_ready", 64'(tready_s), 64'd0);
        chk("full_head", 64'(dout), 64'd0);
        tready_in = 1'b1;
        send_beat(32'd4, 4'h3, 1'b0);
        send_beat(32'd5, 4'h3, 1'b1);
        drain();
        chk("full_frame", 64'(fcnt), 64'd1);

        // Simultaneous write and pop at occupancy 2.
        do_reset();
        send_beat(32'hA0, 4'h1, 1'b0);
        send_beat(32'hA1, 4'h2, 1'b0);
        chk("simul_pre", 64'(fcount), 64'd2);
        tvalid    = 1'b1;
        tdata     = 32'hA2;
        tstrb     = 4'h4;
        tready_in = 1'b1;
        cyc();
        tvalid    = 1'b0;
        tready_in = 1'b0;
        chk("simul_count", 64'(fcount), 64'd2);
        chk("simul_head", 64'(dout), 64'hA1);
        drain();

        // Randomized valid/ready: 100 beats in 5 packets of 20.
        do_reset();
        idx = 0;
        guard = 0;
        while (idx < 100 && guard < 5000) begin
            tvalid    = 1'($urandom_range(0, 1));
            tready_in = 1'($urandom_range(0, 1));
            tdata     = $urandom;
            tstrb     = 4'($urandom);
            tlast     = (idx % 20) == 19;
            acc = tvalid && tready_s;
            cyc();
            if (acc) idx++;
            guard++;
        end
        if (idx < 100) chk("rand_timeout", 64'(idx), 64'd100);
        tvalid = 1'b0;
        tlast  = 1'b0;
        drain();
        chk("rand_frame", 64'(fcnt), 64'd5);
        chk("rand_empty", 64'(fcount), 64'd0);

        // Reset with three beats buffered mid-packet.
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(32'h100 + W'(i), 4'hF, 1'b0);
        chk("mid_count", 64'(fcount), 64'd3);
        tvalid = 1'b1;
        tdata  = 32'h1FF;
        rst    = 1'b1;
        cyc();
        chk("mid_rst_count", 64'(fcount), 64'd0);
        chk("mid_rst_tvalid", 64'(vout), 64'd0);
        chk("mid_rst_frame", 64'(fcnt), 64'd0);
        rst    = 1'b0;
        tvalid = 1'b0;
        cyc();
        tready_in = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(32'h200 + W'(i), 4'hF, i == 3);
        drain();
        chk("mid_after_frame", 64'(fcnt), 64'd1);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
